// File: rtl/processor_8085_param_if.sv
// rtl/processor_8085_param_if.sv - control, load and status bundle for processor_8085_param
// master drives start and program/register loads; slave returns flags, ACC, pc and status.
interface processor_8085_param_if #(
  parameter int DW     = 8,
  parameter int NREG   = 8,
  parameter int PDEPTH = 64
);
  localparam int AW = $clog2(PDEPTH);
  localparam int RW = $clog2(NREG);

  logic          start;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          rf_we;
  logic [RW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic          z;
  logic          cy;
  logic [DW-1:0] ACC;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;

  modport master (
    output start, prog_we, prog_addr, prog_data, rf_we, rf_addr, rf_wdata,
    input  z, cy, ACC, pc, busy, halted
  );

  modport slave (
    input  start, prog_we, prog_addr, prog_data, rf_we, rf_addr, rf_wdata,
    output z, cy, ACC, pc, busy, halted
  );
endinterface

// File: rtl/processor_8085_param.sv
// rtl/processor_8085_param.sv - 8085-flavoured accumulator core, 3 clocks per instruction
// Program memory survives reset; ACC, flags and registers survive start.
module processor_8085_param #(
  parameter int DW     = 8,
  parameter int NREG   = 8,
  parameter int PDEPTH = 64
) (
  input logic                    clk,
  input logic                    reset,
  processor_8085_param_if.slave  bus
);
  localparam int AW  = $clog2(PDEPTH);
  localparam int RW  = $clog2(NREG);
  localparam int OPW = (DW > AW) ? DW : AW;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [DW-1:0]  acc_q, acc_d;
  logic           z_q, z_d, cy_q, cy_d;
  logic [3:0]     op_q, op_d;
  logic [OPW-1:0] opnd_q, opnd_d;
  logic [DW-1:0]  rf_q [NREG];
  logic [15:0]    pmem [PDEPTH];

  logic           busy;
  logic           rf_wr;
  logic [RW-1:0]  rf_wa;
  logic [DW-1:0]  rf_wd;
  logic [RW-1:0]  rn_idx;
  logic [DW-1:0]  rn_val;
  logic           cin;
  logic [DW:0]    sum, diff;
  logic [AW-1:0]  pc_inc;

  assign busy   = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign rn_idx = opnd_q[RW-1:0];
  assign rn_val = rf_q[rn_idx];
  assign cin    = (op_q == 4'h5) ? cy_q : 1'b0;
  assign sum    = {1'b0, acc_q} + {1'b0, rn_val} + {{DW{1'b0}}, cin};
  assign diff   = {1'b0, acc_q} - {1'b0, rn_val};
  assign pc_inc = pc_q + {{(AW-1){1'b0}}, 1'b1};

  // Loads are only accepted while the core is parked, so they can never race an EXEC write.
  always_ff @(posedge clk) begin
    if (bus.prog_we && !busy) pmem[bus.prog_addr] <= bus.prog_data;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    z_d     = z_q;
    cy_d    = cy_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    rf_wr   = 1'b0;
    rf_wa   = bus.rf_addr;
    rf_wd   = bus.rf_wdata;
    case (state_q)
      S_IDLE, S_HALT: begin
        rf_wr = bus.rf_we;
        if (bus.start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        op_d    = pmem[pc_q][15:12];
        opnd_d  = pmem[pc_q][OPW-1:0];
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (op_q)
          4'h1: acc_d = rn_val;
          4'h2: begin
            rf_wr = 1'b1;
            rf_wa = rn_idx;
            rf_wd = acc_q;
          end
          4'h3: acc_d = opnd_q[DW-1:0];
          4'h4, 4'h5: {cy_d, acc_d} = sum;
          4'h6: {cy_d, acc_d} = diff;
          4'h7: begin acc_d = acc_q & rn_val; cy_d = 1'b0; end
          4'h8: begin acc_d = acc_q | rn_val; cy_d = 1'b0; end
          4'h9: begin acc_d = acc_q ^ rn_val; cy_d = 1'b0; end
          4'hA: acc_d = ~acc_q;
          4'hB: pc_d = opnd_q[AW-1:0];
          4'hC: if (z_q)  pc_d = opnd_q[AW-1:0];
          4'hD: if (cy_q) pc_d = opnd_q[AW-1:0];
          4'hE: if (!z_q) pc_d = opnd_q[AW-1:0];
          4'hF: state_d = S_HALT;
          default: ;
        endcase
        // z tracks only the arithmetic/logic group.
        if (op_q >= 4'h4 && op_q <= 4'h9) z_d = (acc_d == '0);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      acc_q   <= '0;
      z_q     <= 1'b0;
      cy_q    <= 1'b0;
      op_q    <= '0;
      opnd_q  <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      cy_q    <= cy_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      if (rf_wr) rf_q[rf_wa] <= rf_wd;
    end
  end

  assign bus.z      = z_q;
  assign bus.cy     = cy_q;
  assign bus.ACC    = acc_q;
  assign bus.pc     = pc_q;
  assign bus.busy   = busy;
  assign bus.halted = (state_q == S_HALT);
endmodule

// File: doc/processor_8085_param.md
PROCESSOR_8085_PARAM -- requirements
Module: processor_8085_param

Interface
REQ-001 The block SHALL provide parameter DW, default 8, meaning accumulator/register data width (legal 4..12).
REQ-002 The block SHALL provide parameter NREG, default 8, meaning register-file depth (power of 2, 2..16); RW = log2(NREG).
REQ-003 The block SHALL provide parameter PDEPTH, default 64, meaning program-memory depth in 16-bit words (power of 2, 4..4096); AW = log2(PDEPTH).
REQ-004 Ports SHALL be:
  clk  in  1  clock, all state updates on rising edge
  reset  in  1  asynchronous active-high reset
  start  in  1  begin execution at pc 0 when not busy
  prog_we  in  1  program-memory write strobe
  prog_addr  in  AW  program write address
  prog_data  in  16  instruction word
  rf_we  in  1  register-file write strobe
  rf_addr  in  RW  register write index
  rf_wdata  in  DW  register write data
  z  out  1  zero flag
  cy  out  1  carry/borrow flag
  ACC  out  DW  accumulator
  pc  out  AW  program counter
  busy  out  1  high in FETCH/DECODE/EXEC
  halted  out  1  high in HALT

Function
REQ-005 Instruction SHALL be [15:12] opcode, [11:0] operand; register index = operand[RW-1:0]; immediate = operand[DW-1:0]; jump target = operand[AW-1:0].
REQ-006 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, HALT; IDLE/HALT --start--> FETCH; FETCH->DECODE->EXEC; EXEC->FETCH, or EXEC->HALT on HLT.
REQ-007 Each instruction SHALL take exactly 3 clocks; results (ACC, flags, register, pc) SHALL be visible after the EXEC edge.
REQ-008 start SHALL reset pc to 0 and clear halted, retaining ACC, flags and registers; start while busy SHALL be ignored.
REQ-009 Opcodes SHALL be: 0 NOP; 1 MOV A,Rn; 2 MOV Rn,A; 3 MVI A,imm; 4 ADD Rn; 5 ADC Rn; 6 SUB Rn; 7 ANA Rn; 8 ORA Rn; 9 XRA Rn; A CMA; B JMP; C JZ; D JC; E JNZ; F HLT.
REQ-010 ADD/ADC SHALL compute DW+1-bit sum, ACC = low DW bits, cy = bit DW; ADC adds cy-in.
REQ-011 SUB SHALL set ACC = (ACC - Rn) mod 2^DW, cy = 1 iff Rn > ACC (unsigned borrow).
REQ-012 ANA/ORA/XRA SHALL clear cy; CMA SHALL invert ACC, flags unchanged.
REQ-013 z SHALL update (ACC result == 0) on ADD, ADC, SUB, ANA, ORA, XRA only; MOV, MVI, CMA, jumps, NOP SHALL leave z and cy unchanged.
REQ-014 Non-jump and not-taken jump SHALL set pc = (pc+1) mod PDEPTH (wrap PDEPTH-1 -> 0); taken jump SHALL set pc = target.
REQ-015 HLT SHALL set pc = pc+1 (mod PDEPTH), enter HALT, assert halted, deassert busy.
REQ-016 prog_we and rf_we SHALL be honoured only when busy = 0 and SHALL be ignored while busy; simultaneous start and write in IDLE/HALT SHALL perform the write in the same edge as the start transition.
REQ-017 Operand bits above the field width SHALL be ignored.

Reset
REQ-018 reset SHALL asynchronously force state IDLE, ACC = 0, z = 0, cy = 0, pc = 0, busy = 0, halted = 0, all registers = 0, mid-instruction included; program memory SHALL be retained.
REQ-019 After reset deasserts, no instruction SHALL execute until start.

Verification
REQ-020 Reset: assert reset mid-EXEC of ADD -> ACC=0, z=0, cy=0, pc=0, busy=0, halted=0 immediately, no register write afterwards.
REQ-021 Sum: R0..R5 = 1..6; program MOV A,R0; ADD R1; ADD R2; HLT; start -> halted after 12 clocks, ACC=6, z=0, cy=0, pc=4.
REQ-022 Carry: R0=1; MVI A,0xFF; ADD R0; ADC R0; HLT -> after ADD ACC=0x00, z=1, cy=1; after ADC ACC=0x02, z=0, cy=0.
REQ-023 Borrow: R4=5; MVI A,3; SUB R4; HLT -> ACC=0xFE, cy=1, z=0; then ANA R4 -> ACC=0x04, cy=0.
REQ-024 Loop: R1=1; MVI A,3; SUB R1 (addr1); JNZ 1; HLT -> SUB executes 3 times, ACC=0, z=1, halted; NOP at PDEPTH-1 followed by pc=0 demonstrates wrap.
REQ-025 Busy lockout: prog_we/rf_we pulsed while busy -> memory/registers unchanged; start while busy -> no pc reset.
